// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI subunit slice.
package spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/spi_subunit_if.sv
// Bundle of SPI pins and the parallel byte interface of the SPI subunit.
// The slave modport is the subunit's view; master is the view of whatever drives it.
interface spi_subunit_if;
  import spi_pkg::*;

  logic                SPI_SCLK;
  logic                SPI_CS;
  logic                SPI_MOSI;
  logic                SPI_MISO;
  logic                miso_en;
  logic [SPI_BITS-1:0] tx_data;
  logic                tx_load;
  logic [SPI_BITS-1:0] rx_data;
  logic                rx_valid;
  logic                rx_error;
  logic                busy;

  modport slave (
    input  SPI_SCLK, SPI_CS, SPI_MOSI, tx_data,
    output SPI_MISO, miso_en, tx_load, rx_data, rx_valid, rx_error, busy
  );

  modport master (
    output SPI_SCLK, SPI_CS, SPI_MOSI, tx_data,
    input  SPI_MISO, miso_en, tx_load, rx_data, rx_valid, rx_error, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a one-flop
// edge detector. rise/fall are single-cycle pulses aligned with level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift the pin through the synchronizer chain and keep one delayed copy for edge detection.
  // NOTE: the reset value matches the pin's idle level so no false edge appears when reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real chain.
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_subunit.sv
// SPI mode-0 responder: oversamples SCLK/CS/MOSI in the clk domain,
// deserializes MOSI into bytes and serializes a user byte onto MISO per frame.
module spi_subunit
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_subunit_if.slave bus
);

  localparam int                CNT_W    = $clog2(SPI_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SPI_BITS - 1);

  // Synchronized pin views
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // FSM and datapath
  state_t                state, state_next;
  logic                  start, stop, shift_in, shift_out;
  logic [SPI_BITS-1:0]   tx_shift;
  logic [SPI_BITS-2:0]   rx_shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  byte_done;
  logic [SPI_BITS-1:0]   rx_data_q;
  logic                  rx_valid_q, tx_load_q, rx_error_q;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.SPI_SCLK),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.SPI_CS),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI takes the same path depth as SCLK so the sampled bit lines up with the SCLK edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.SPI_MOSI),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle action strobes; a CS rise wins over a same-cycle SCLK edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          stop       = 1'b1;
        end else begin
          shift_in  = sclk_rise;
          shift_out = sclk_fall;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      byte_done  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      rx_error_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      rx_error_q <= 1'b0;
      if (start) begin
        tx_shift  <= bus.tx_data;
        tx_load_q <= 1'b1;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else if (stop) begin
        // Partial byte is dropped; MISO returns low once deselected.
        tx_shift   <= '0;
        rx_error_q <= (bit_cnt != '0);
        bit_cnt    <= '0;
        byte_done  <= 1'b0;
      end else begin
        if (shift_in) begin
          rx_shift <= {rx_shift[SPI_BITS-3:0], mosi_s};
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            rx_data_q  <= {rx_shift, mosi_s};
            rx_valid_q <= 1'b1;
            byte_done  <= 1'b1;
          end
        end
        if (shift_out) begin
          if (byte_done) begin
            tx_shift  <= bus.tx_data;
            tx_load_q <= 1'b1;
            byte_done <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[SPI_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign bus.SPI_MISO = tx_shift[SPI_BITS-1];
  assign bus.miso_en  = (state == ACTIVE);
  assign bus.busy     = (state == ACTIVE);
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_load  = tx_load_q;
  assign bus.rx_error = rx_error_q;

endmodule

// File: tb/tb_spi_subunit.sv
// Self-checking bench for spi_subunit: directed frames from the test plan plus
// randomized frames, compared against a frame-level model of the responder.
module tb_spi_subunit;
  import spi_pkg::*;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_subunit_if bus ();

  spi_subunit #(.SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  logic [7:0]    exp_rx[$];   // bytes the controller has sent, awaiting rx_valid
  logic [7:0]    loaded[$];   // tx_data values latched by tx_load in the current frame
  logic [7:0]    tx_plan[$];  // next tx_data values to present after each tx_load
  logic [7:0]    frame_q[$];  // MOSI bytes of the frame being driven
  logic [7:0]    recv[$];     // MISO bytes seen by the controller
  logic [7:0]    last_rx = 8'h00;
  logic [7:0]    e_byte;
  logic [SYNC:0] cs_hist;     // CS pin as captured on recent clk edges
  int            cnt_rv = 0, cnt_tl = 0, cnt_re = 0;
  logic          prev_rv, prev_tl, prev_re;
  logic          exp_sel;

  // Per-cycle compare: selection follows the CS pin SYNC+1 edges late; pulses carry model data.
  initial begin
    cs_hist = '1;
    prev_rv = 1'b0;
    prev_tl = 1'b0;
    prev_re = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cs_hist = '1;
        prev_rv = 1'b0;
        prev_tl = 1'b0;
        prev_re = 1'b0;
      end else begin
        exp_sel = ~cs_hist[SYNC];
        check("busy", bus.busy, exp_sel);
        check("miso_en", bus.miso_en, exp_sel);
        if (!exp_sel) check("miso_idle", bus.SPI_MISO, 1'b0);
        if (bus.rx_valid) begin
          cnt_rv++;
          check("rx_valid_width", prev_rv, 1'b0);
          if (exp_rx.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_valid_unexpected: got rx_data 0x%0h expected no pulse at %0t", bus.rx_data, $time);
          end else begin
            e_byte = exp_rx.pop_front();
            check("rx_data", bus.rx_data, e_byte);
            last_rx = e_byte;
          end
        end
        if (bus.tx_load) begin
          cnt_tl++;
          check("tx_load_width", prev_tl, 1'b0);
          loaded.push_back(bus.tx_data);
          bus.tx_data = (tx_plan.size() != 0) ? tx_plan.pop_front() : 8'($urandom);
        end
        if (bus.rx_error) begin
          cnt_re++;
          check("rx_error_width", prev_re, 1'b0);
        end
        prev_rv = bus.rx_valid;
        prev_tl = bus.tx_load;
        prev_re = bus.rx_error;
        cs_hist = {cs_hist[SYNC-1:0], bus.SPI_CS};
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one mode-0 frame of nbits from frame_q with half-period hp, then check the frame totals.
  task automatic run_frame(input int nbits, input int hp);
    int         rv0, tl0, re0, nfull;
    logic [7:0] shreg;
    rv0   = cnt_rv;
    tl0   = cnt_tl;
    re0   = cnt_re;
    nfull = nbits / 8;
    shreg = 8'h00;
    recv.delete();
    loaded.delete();
    for (int k = 0; k < nfull; k++) exp_rx.push_back(frame_q[k]);
    bus.SPI_MOSI = frame_q[0][7];
    bus.SPI_CS   = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.SPI_MOSI = frame_q[i/8][7 - (i % 8)];
      wait_cyc(hp);
      shreg = {shreg[6:0], bus.SPI_MISO};
      bus.SPI_SCLK = 1'b1;
      wait_cyc(hp);
      bus.SPI_SCLK = 1'b0;
      if ((i % 8) == 7) recv.push_back(shreg);
    end
    wait_cyc(hp);
    bus.SPI_CS   = 1'b1;
    bus.SPI_MOSI = 1'b0;
    wait_cyc(SYNC + 2);
    check("miso_en_off", bus.miso_en, 1'b0);
    wait_cyc(hp);
    check("rx_valid_count", cnt_rv - rv0, nfull);
    check("tx_load_count", cnt_tl - tl0, nfull + 1);
    check("rx_error_count", cnt_re - re0, (nbits % 8) != 0);
    check("rx_pending", exp_rx.size(), 0);
    exp_rx.delete();
    check("rx_hold", bus.rx_data, last_rx);
    for (int k = 0; k < nfull; k++) begin
      if (k < loaded.size()) check("miso_byte", recv[k], loaded[k]);
    end
  endtask

  int sv_rv, sv_tl, sv_re, nb, nbits, hp;

  initial begin
    bus.SPI_SCLK = 1'b0;
    bus.SPI_CS   = 1'b1;
    bus.SPI_MOSI = 1'b0;
    bus.tx_data  = 8'h00;
    rst          = 1'b1;

    // Reset values
    wait_cyc(3);
    check("rst_miso", bus.SPI_MISO, 1'b0);
    check("rst_miso_en", bus.miso_en, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_tx_load", bus.tx_load, 1'b0);
    check("rst_rx_error", bus.rx_error, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    wait_cyc(3);

    // Single byte both ways
    bus.tx_data = 8'hA5;
    frame_q     = {8'h3C};
    run_frame(8, SYNC + 4);
    check("single_rx", bus.rx_data, 8'h3C);
    check("single_miso", recv[0], 8'hA5);

    // Three bytes with CS held; tx_data follows each tx_load
    bus.tx_data = 8'h11;
    tx_plan     = {8'h22, 8'h33};
    frame_q     = {8'h01, 8'h80, 8'hFF};
    run_frame(24, SYNC + 3);
    check("multi_rx_last", bus.rx_data, 8'hFF);
    check("multi_miso0", recv[0], 8'h11);
    check("multi_miso1", recv[1], 8'h22);
    check("multi_miso2", recv[2], 8'h33);

    // Abort after 5 bits: rx_data keeps the previous byte
    tx_plan.delete();
    frame_q = {8'h96};
    run_frame(5, SYNC + 3);
    check("abort_rx_hold", bus.rx_data, 8'hFF);

    // Reset in the middle of a frame
    bus.tx_data  = 8'h77;
    bus.SPI_MOSI = 1'b1;
    bus.SPI_CS   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(SYNC + 3);
      bus.SPI_SCLK = 1'b1;
      wait_cyc(SYNC + 3);
      bus.SPI_SCLK = 1'b0;
    end
    wait_cyc(2);
    rst = 1'b1;
    #1;
    check("mid_rst_miso", bus.SPI_MISO, 1'b0);
    check("mid_rst_miso_en", bus.miso_en, 1'b0);
    check("mid_rst_rx_data", bus.rx_data, 8'h00);
    check("mid_rst_rx_valid", bus.rx_valid, 1'b0);
    check("mid_rst_tx_load", bus.tx_load, 1'b0);
    check("mid_rst_rx_error", bus.rx_error, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    bus.SPI_CS   = 1'b1;
    bus.SPI_MOSI = 1'b0;
    exp_rx.delete();
    tx_plan.delete();
    last_rx = 8'h00;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    bus.tx_data = 8'h3A;
    frame_q     = {8'h5A};
    run_frame(8, SYNC + 3);
    check("post_rst_rx", bus.rx_data, 8'h5A);
    check("post_rst_miso", recv[0], 8'h3A);

    // SCLK toggling while deselected
    sv_rv = cnt_rv;
    sv_tl = cnt_tl;
    sv_re = cnt_re;
    for (int i = 0; i < 16; i++) begin
      bus.SPI_MOSI = 1'($urandom);
      wait_cyc(SYNC + 2);
      bus.SPI_SCLK = ~bus.SPI_SCLK;
    end
    bus.SPI_SCLK = 1'b0;
    wait_cyc(SYNC + 4);
    check("desel_rx_valid", cnt_rv - sv_rv, 0);
    check("desel_tx_load", cnt_tl - sv_tl, 0);
    check("desel_rx_error", cnt_re - sv_re, 0);

    // Minimum legal half-period
    bus.tx_data = 8'hC3;
    frame_q     = {8'hC3};
    run_frame(8, SYNC + 2);
    check("min_rx", bus.rx_data, 8'hC3);
    check("min_miso", recv[0], 8'hC3);

    // Randomized frames, some aborted
    for (int f = 0; f < 24; f++) begin
      nb = $urandom_range(1, 3);
      frame_q.delete();
      for (int k = 0; k < nb; k++) frame_q.push_back(8'($urandom));
      nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nb * 8 - 1) : nb * 8;
      hp = $urandom_range(SYNC + 2, SYNC + 5);
      tx_plan.delete();
      bus.tx_data = 8'($urandom);
      run_frame(nbits, hp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
